// File: rtl/shape_scene_scheduler.sv
// shape_scene_scheduler: frame-synchronous scene controller for the pixel path.
// Picks one of four shape generators (stripes, moving rectangle, ellipse,
// parabola), animates the rectangle once per frame and takes mode/pause
// commands from the push buttons.
// Optional feature macro: SHAPE_SCENE_AUTO_CYCLE_EN (auto mode advance every
// auto_frames unpaused frames, flagged on led[4]).
`timescale 1ns/1ps

module shape_scene_scheduler #(
    parameter int unsigned screen_width  = 640,
    parameter int unsigned screen_height = 480,
    parameter int unsigned w_x           = $clog2(screen_width),
    parameter int unsigned w_y           = $clog2(screen_height),
    parameter int unsigned w_red         = 4,
    parameter int unsigned w_green       = 4,
    parameter int unsigned w_blue        = 4,
    parameter int unsigned w_key         = 4,
    parameter int unsigned w_led         = 8,
    parameter int unsigned rect_w        = 64,
    parameter int unsigned rect_h        = 48,
    parameter int unsigned step          = 4,
    parameter int unsigned auto_frames   = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [w_key-1:0]   key,
    input  logic [w_x-1:0]     x,
    input  logic [w_y-1:0]     y,
    output logic [w_red-1:0]   red,
    output logic [w_green-1:0] green,
    output logic [w_blue-1:0]  blue,
    output logic [w_led-1:0]   led
);

    typedef enum logic [1:0] {
        MODE_STRIPES  = 2'd0,
        MODE_RECT     = 2'd1,
        MODE_ELLIPSE  = 2'd2,
        MODE_PARABOLA = 2'd3
    } mode_e;

    localparam int unsigned w_pos = w_x + 1;
    localparam int unsigned w_sq  = 2 * w_x + 2;

    localparam logic [w_pos-1:0] pos_max      = w_pos'(screen_width - rect_w);
    localparam logic [w_pos-1:0] pos_step     = w_pos'(step);
    localparam logic [w_pos-1:0] rect_w_v     = w_pos'(rect_w);
    localparam logic [w_pos-1:0] x_limit      = w_pos'(screen_width);
    localparam logic [w_y:0]     y_limit      = (w_y + 1)'(screen_height);
    localparam logic [w_y-1:0]   y_third      = w_y'(screen_height / 3);
    localparam logic [w_y-1:0]   y_two_thirds = w_y'((2 * screen_height) / 3);
    localparam logic [w_y-1:0]   y_rect_top   = w_y'(screen_height / 2);
    localparam logic [w_y-1:0]   y_rect_bot   = w_y'(screen_height / 2 + rect_h);
    localparam logic [w_sq-1:0]  ell_r2       = w_sq'((screen_width * screen_width) / 4);

    // Key synchronizer, edge detect and frame-start tracking
    logic [1:0]       key_meta_q, key_sync_q, key_prev_q;
    logic             origin_prev_q;
    // Scene state
    mode_e            mode_q;
    logic [w_pos-1:0] pos_q, pos_d;
    logic             pending_q, pending_d;
    logic             paused_q, paused_d;
    // Registered pixel outputs
    logic [w_red-1:0]   red_q, red_d;
    logic [w_green-1:0] green_q, green_d;
    logic [w_blue-1:0]  blue_q, blue_d;

    logic [1:0]       key_rise_c;
    logic             origin_c;
    logic             frame_start_c;
    logic             advance_c;
    logic             auto_hit_c;
    logic             auto_en_c;
    logic [w_pos-1:0] pos_next_c;
    logic [w_sq-1:0]  xx_c, yy2_c;
    logic [w_pos-1:0] x_ext_c;

    logic unused_key_bits;
    assign unused_key_bits = ^key[w_key-1:2];

`ifdef SHAPE_SCENE_AUTO_CYCLE_EN
    localparam int unsigned cnt_w = (auto_frames > 1) ? $clog2(auto_frames) : 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(auto_frames - 1);

    logic [cnt_w-1:0] frame_cnt_q;

    assign auto_en_c  = 1'b1;
    assign auto_hit_c = frame_start_c && !paused_q && (frame_cnt_q == cnt_last);

    // Unpaused frame counter; a manual next-mode press restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (key_rise_c[0]) begin
            frame_cnt_q <= '0;
        end else if (frame_start_c && !paused_q) begin
            frame_cnt_q <= auto_hit_c ? '0 : frame_cnt_q + cnt_w'(1);
        end
    end
`else
    logic unused_auto_frames;
    assign unused_auto_frames = ^auto_frames;
    assign auto_en_c  = 1'b0;
    assign auto_hit_c = 1'b0;
`endif

    // Key edges and a single frame-start pulse per (0,0) arrival
    always_comb begin
        key_rise_c    = key_sync_q & ~key_prev_q;
        origin_c      = (x == '0) && (y == '0);
        frame_start_c = origin_c && !origin_prev_q;
        advance_c     = frame_start_c && pending_q;
    end

    // Next pending/pause/rectangle position
    always_comb begin
        pos_next_c = pos_q + pos_step;
        pos_d      = pos_q;
        if (frame_start_c && !paused_q) begin
            pos_d = (pos_next_c > pos_max) ? '0 : pos_next_c;
        end
        pending_d = advance_c ? key_rise_c[0] : (pending_q | key_rise_c[0]);
        pending_d = pending_d | auto_hit_c;
        paused_d  = paused_q ^ key_rise_c[1];
    end

    // Shape generators selected by the registered mode; blanking outside the active area
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        x_ext_c = {1'b0, x};
        xx_c    = w_sq'(x) * w_sq'(x);
        yy2_c   = (w_sq'(y) * w_sq'(y)) << 1;
        if ((x_ext_c < x_limit) && ({1'b0, y} < y_limit)) begin
            unique case (mode_q)
                MODE_STRIPES: begin
                    if (y < y_third) begin
                        red_d   = '1;
                        green_d = '1;
                        blue_d  = '1;
                    end else if (y < y_two_thirds) begin
                        blue_d = '1;
                    end else begin
                        red_d = '1;
                    end
                end
                MODE_RECT: begin
                    if ((x_ext_c >= pos_q) && (x_ext_c < pos_q + rect_w_v) &&
                        (y >= y_rect_top) && (y < y_rect_bot)) begin
                        green_d = '1;
                    end
                end
                MODE_ELLIPSE: begin
                    if ((xx_c + yy2_c) < ell_r2) begin
                        red_d = '1;
                    end
                end
                MODE_PARABOLA: begin
                    if (xx_c[w_x +: w_y] < y) begin
                        blue_d = '1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register: synchronizer, mode FSM, scene state and pixel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_q    <= '0;
            key_sync_q    <= '0;
            key_prev_q    <= '0;
            origin_prev_q <= 1'b0;
            mode_q        <= MODE_STRIPES;
            pos_q         <= '0;
            pending_q     <= 1'b0;
            paused_q      <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            key_meta_q    <= key[1:0];
            key_sync_q    <= key_meta_q;
            key_prev_q    <= key_sync_q;
            origin_prev_q <= origin_c;
            if (advance_c) begin
                unique case (mode_q)
                    MODE_STRIPES:  mode_q <= MODE_RECT;
                    MODE_RECT:     mode_q <= MODE_ELLIPSE;
                    MODE_ELLIPSE:  mode_q <= MODE_PARABOLA;
                    MODE_PARABOLA: mode_q <= MODE_STRIPES;
                    default:       mode_q <= MODE_STRIPES;
                endcase
            end
            pos_q     <= pos_d;
            pending_q <= pending_d;
            paused_q  <= paused_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign led   = w_led'({auto_en_c, paused_q, pending_q, mode_q});

endmodule
